word_to_byte_serializer: RTL and testbench

- Narrowing counterpart of the datapath's 8-to-16 zero-extend path.
- Accepts 16-bit words through a valid/ready handshake and emits them as 8-bit bytes, low byte first, through a second valid/ready handshake.
- Optional compact mode sends only the low byte when the high byte is zero, i.e. when the word is a zero-extended byte.
- Sits between the 16-bit datapath result bus and 8-bit memory/IO ports.

---
 rtl/word_to_byte_serializer.sv | 119 +++++++++++
 tb/tb_word_to_byte_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/word_to_byte_serializer.sv
// Splits 16-bit words into bytes, low byte first; optional compact mode (SERIALIZER_COMPACT_EN) sends one byte for zero-extended words.
// Latency: accepted word shows its low byte the cycle after acceptance; back-to-back words run without bubbles.
// Backpressure: output holds stable while out_ready is low; in_ready only rises when idle or on the final byte's transfer.
module word_to_byte_serializer #(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*BYTE_W-1:0]   in_word,
  input  logic                  in_compact,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_W-1:0]     out_byte,
  output logic                  out_last,
  output logic [CNT_W-1:0]      words_done
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   hold_hi_q, hold_hi_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    done_q, done_d;
  logic                hi_zero;
  logic                single;
  logic                xfer;
  logic                accept;

  assign hi_zero = (in_word[2*BYTE_W-1:BYTE_W] == '0);

`ifdef SERIALIZER_COMPACT_EN
  assign single = in_compact && hi_zero;
`else
  logic unused_compact;
  assign unused_compact = in_compact ^ hi_zero;
  assign single = 1'b0;
`endif

  assign out_valid  = (state_q != IDLE);
  assign xfer       = out_valid && out_ready;
  // Combinational from out_ready so a new word can load on the final byte's transfer.
  assign in_ready   = (state_q == IDLE) || (xfer && last_q);
  assign accept     = in_valid && in_ready;
  assign out_byte   = byte_q;
  assign out_last   = last_q;
  assign words_done = done_q;

  always_comb begin
    state_d   = state_q;
    hold_hi_d = hold_hi_q;
    byte_d    = byte_q;
    last_d    = last_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SEND_LO;
          hold_hi_d = in_word[2*BYTE_W-1:BYTE_W];
          byte_d    = in_word[BYTE_W-1:0];
          last_d    = single;
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          if (last_q) begin
            done_d = done_q + CNT_W'(1);
            if (accept) begin
              state_d   = SEND_LO;
              hold_hi_d = in_word[2*BYTE_W-1:BYTE_W];
              byte_d    = in_word[BYTE_W-1:0];
              last_d    = single;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = SEND_HI;
            byte_d  = hold_hi_q;
            last_d  = 1'b1;
          end
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          done_d = done_q + CNT_W'(1);
          if (accept) begin
            state_d   = SEND_LO;
            hold_hi_d = in_word[2*BYTE_W-1:BYTE_W];
            byte_d    = in_word[BYTE_W-1:0];
            last_d    = single;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_hi_q <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_hi_q <= hold_hi_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Directed and random stimulus for word_to_byte_serializer against a byte-queue reference model.
module tb_word_to_byte_serializer;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;
`ifdef SERIALIZER_COMPACT_EN
  localparam bit COMPACT = 1'b1;
`else
  localparam bit COMPACT = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [2*BYTE_W-1:0] in_word;
  logic                in_compact;
  logic                out_valid;
  logic                out_ready;
  logic [BYTE_W-1:0]   out_byte;
  logic                out_last;
  logic [CNT_W-1:0]    words_done;

  word_to_byte_serializer #(.BYTE_W(BYTE_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_compact (in_compact),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .words_done (words_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Pending output bytes as {last, byte}; exp_cnt counts words completed since reset.
  logic [BYTE_W:0] q[$];
  int              exp_cnt;
  int              done_base;
  bit              rand_rdy;
  bit              accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check/update the model at the falling edge, then return just after the rising edge.
  task automatic step();
    logic exp_rdy;
    logic [CNT_W-1:0] exp_done;
    @(negedge clk);
    accepted = 1'b0;
    if (reset) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        chk("out_byte", {24'd0, out_byte}, {24'd0, q[0][BYTE_W-1:0]});
        chk("out_last", {31'd0, out_last}, {31'd0, q[0][BYTE_W]});
      end
      exp_done = CNT_W'(done_base + exp_cnt);
      chk("words_done", {16'd0, words_done}, {16'd0, exp_done});
      exp_rdy = (q.size() == 0) || (out_ready && q[0][BYTE_W]);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      accepted = in_valid && in_ready;
      if (out_valid && out_ready && q.size() != 0) begin
        if (q[0][BYTE_W]) exp_cnt++;
        void'(q.pop_front());
      end
      if (accepted) begin
        if (COMPACT && in_compact && in_word[15:8] == 8'h00) begin
          q.push_back({1'b1, in_word[7:0]});
        end else begin
          q.push_back({1'b0, in_word[7:0]});
          q.push_back({1'b1, in_word[15:8]});
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] w, input logic c);
    in_valid   = 1'b1;
    in_word    = w;
    in_compact = c;
    accepted   = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) step();
    chk("accept_in_time", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    chk("drain_in_time", q.size(), 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_word = '0; in_compact = 1'b0;
    out_ready = 1'b1; rand_rdy = 1'b0; done_base = 0; exp_cnt = 0;
    repeat (2) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_words_done", {16'd0, words_done}, 32'd0);
    reset = 1'b0;

    // Plain two-byte word.
    send(16'h1234, 1'b0);
    drain();
    chk("one_word_done", {16'd0, words_done}, 32'd1);

    // Zero-extended byte with compact request.
    send(16'h0011, 1'b1);
    drain();

    // Backpressure holds the low byte and blocks input.
    out_ready = 1'b0;
    send(16'hABCD, 1'b0);
    in_valid = 1'b1; in_word = 16'h9999;
    repeat (5) step();
    chk("bp_hold_byte", {24'd0, out_byte}, 32'h0000_00CD);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    drain();

    // Back-to-back words with no idle cycle between them.
    out_ready = 1'b1;
    send(16'h0102, 1'b0);
    send(16'h0304, 1'b0);
    drain();

    // All-zero compact word.
    send(16'h0000, 1'b1);
    drain();

    // Random words, gaps and backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:8] = 8'h00;
      repeat ($urandom_range(0, 2)) step();
      send(w, 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset while the high byte is waiting.
    out_ready = 1'b0;
    send(16'h5566, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("pre_rst_hi_byte", {24'd0, out_byte}, 32'h0000_0055);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_done", {16'd0, words_done}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Counter wrap from all-ones.
    done_base = 16'hFFFF;
    force dut.done_q = 16'hFFFF;
    step();
    release dut.done_q;
    step();
    send(16'h7788, 1'b0);
    drain();
    chk("wrap_done", {16'd0, words_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
